spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 slave (CPOL=0, CPHA=0), the responder end for spi_master. Oversamples spi_clk,
//  spi_csn and spi_mosi in the sys_clk domain and deserialises MOSI into DATA_WIDTH-bit words.
//  Serialises a host-supplied TX word onto MISO in the same frame.
//  Sits between the SPI pins and on-chip register/command logic; single chip-select.
// PARAMETERS
//  DATA_WIDTH  8            bits per word; legal range 2..32
//  TX_ORDER    "MSB_FIRST"  MISO bit order, "MSB_FIRST" or "LSB_FIRST"
//  RX_ORDER    "MSB_FIRST"  MOSI bit order; first received bit lands in data_recv[DW-1] or [0]
// PORTS
//  sys_clk        in   1   system clock; sole clock, all logic posedge sys_clk
//  rst            in   1   reset, synchronous, active-high
//  spi_clk        in   1   SPI clock from master, asynchronous to sys_clk
//  spi_csn        in   1   chip select, active-low, asynchronous
//  spi_mosi       in   1   serial data from master
//  spi_miso       out  1   serial data to master
//  spi_miso_oe    out  1   MISO output enable; 1 only while frame active
//  tx_data        in   DW  next word to transmit
//  tx_vld         in   1   tx_data valid
//  tx_rdy         out  1   TX holding register empty; transfer when tx_vld&tx_rdy
//  data_recv      out  DW  last complete received word, held until next word completes
//  data_recv_vld  out  1   one-cycle pulse when data_recv updates
//  tx_underrun    out  1   one-cycle pulse: word boundary reached with holding register empty
//  spi_busy       out  1   1 while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, spi_miso=0, spi_miso_oe=0, data_recv=0, data_recv_vld=0, tx_underrun=0,
//   spi_busy=0, tx_rdy=1 (holding empty), bit_cnt=0, shift registers=0. Reset mid-frame aborts.
//  Sync: spi_clk/spi_csn/spi_mosi each through 2-FF synchroniser, plus a third FF on clk/csn for
//   edge detect. Requirement: sys_clk >= 8x spi_clk and CSN setup >= 4 sys_clk before first rise.
//  FSM: IDLE -> LOAD on synced csn fall; LOAD -> SHIFT after 1 cycle; SHIFT -> IDLE on synced
//   csn rise (any bit position). No other transitions.
//  LOAD: tx shift reg <- holding reg (holding marked empty) and first TX bit driven on spi_miso,
//   spi_miso_oe=1. Holding empty -> shift reg <- 0, tx_underrun pulses.
//  SHIFT, spi_clk rise: sample synced mosi into rx shift reg; bit_cnt++.
//   bit_cnt reaches DW: data_recv <= rx word, data_recv_vld pulses next cycle, bit_cnt <= 0,
//   tx shift reg reloaded from holding (underrun rule as LOAD).
//  SHIFT, spi_clk fall: advance tx shift reg, drive next bit; suppressed on the fall directly
//   after a word-boundary reload (reloaded bit 0 already on MISO).
//  Handshake: tx_rdy = ~hold_full. If tx_vld&tx_rdy in the same cycle as a reload with holding
//   empty, tx_data bypasses straight into the tx shift reg (no underrun), holding stays empty.
//  Frame end / abort (csn rise): partial RX bits discarded, no data_recv_vld; bit_cnt <= 0;
//   spi_miso=0, spi_miso_oe=0 same cycle; holding register contents retained.
//  Simultaneous csn rise and clk rise in one sys_clk cycle: csn rise wins, sample ignored.
//  bit_cnt width = clog2(DW+1); never exceeds DW.
// STRUCTURE
//  spi_defines.vh: state encodings (IDLE/LOAD/SHIFT), order string constants.
//  Sub-module spi_sync_edge (2-FF sync + rise/fall pulse outputs), instanced for clk and csn;
//   mosi uses its sync output only. Remainder (FSM, counters, shifters) in spi_slave.
// TESTING
//  Bench pairs spi_slave with spi_master (DW=8), sys_clk 100 MHz, SPI clk 10 MHz.
//  1 Preload tx 0xA5, master sends 0x3C -> data_recv=0x3C, one vld pulse; master receives 0xA5.
//  2 Holding empty, frame of 0x81 -> tx_underrun pulse at LOAD, MISO all 0, data_recv=0x81.
//  3 Three back-to-back words, tx_vld refilled each vld -> RX 0x11,0x22,0x33, TX match, no underrun.
//  4 csn deasserted after 5 bits -> no vld, data_recv keeps old value, next full frame correct.
//  5 tx_vld at exact reload cycle with holding empty -> bypass, word sent, no underrun.
//  6 rst pulsed mid-word -> all outputs at reset values next cycle; next frame correct.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave: FSM state encoding and bit-order strings.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2
    } spi_state_e;

    localparam string OrderMsbFirst = "MSB_FIRST";
    localparam string OrderLsbFirst = "LSB_FIRST";

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin and host-side handshake bundle for spi_slave; the slave modport is the DUT view.
interface spi_slave_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  spi_clk;
    logic                  spi_csn;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_vld;
    logic                  tx_rdy;
    logic [DATA_WIDTH-1:0] data_recv;
    logic                  data_recv_vld;
    logic                  tx_underrun;
    logic                  spi_busy;

    modport slave (
        input  spi_clk, spi_csn, spi_mosi, tx_data, tx_vld,
        output spi_miso, spi_miso_oe, tx_rdy, data_recv, data_recv_vld, tx_underrun, spi_busy
    );

    modport master (
        output spi_clk, spi_csn, spi_mosi, tx_data, tx_vld,
        input  spi_miso, spi_miso_oe, tx_rdy, data_recv, data_recv_vld, tx_underrun, spi_busy
    );
endinterface

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a third flop for rise/fall pulses.
module spi_slave_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Chain clears to 0 so a reset taken while CSN is low cannot fake a CSN fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_dly;
    assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled in the system clock domain, deserialises MOSI and serialises a
// host-supplied word onto MISO through a one-deep holding register.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter string       TX_ORDER   = "MSB_FIRST",
    parameter string       RX_ORDER   = "MSB_FIRST"
) (
    input  logic          i_sys_clk,
    input  logic          i_rst,
    spi_slave_if.slave    io_bus
);
    localparam int unsigned CntW       = $clog2(DATA_WIDTH + 1);
    localparam bit          TxMsbFirst = (TX_ORDER == OrderMsbFirst);
    localparam bit          RxMsbFirst = (RX_ORDER == OrderMsbFirst);

    spi_state_e            r_state;
    spi_state_e            w_state_next;
    logic [CntW-1:0]       r_bit_cnt;
    logic [CntW-1:0]       w_bit_cnt_next;
    logic [CntW-1:0]       w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] w_tx_next;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_hold_next;
    logic                  r_hold_full;
    logic                  w_hold_full_next;
    logic [DATA_WIDTH-1:0] r_data_recv;
    logic [DATA_WIDTH-1:0] w_data_recv_next;
    logic                  r_data_recv_vld;
    logic                  w_data_recv_vld_next;
    logic                  r_tx_underrun;
    logic                  w_tx_underrun_next;
    logic                  r_miso;
    logic                  w_miso_next;
    logic                  r_miso_oe;
    logic                  w_miso_oe_next;
    logic                  r_skip_fall;
    logic                  w_skip_fall_next;
    logic                  w_reload;

    logic w_clk_rise;
    logic w_clk_fall;
    logic w_csn_rise;
    logic w_csn_fall;
    logic r_mosi_meta;
    logic r_mosi_sync;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word);
        return TxMsbFirst ? word[DATA_WIDTH-1] : word[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] word);
        return TxMsbFirst ? {word[DATA_WIDTH-2:0], 1'b0} : {1'b0, word[DATA_WIDTH-1:1]};
    endfunction

    spi_slave_sync_edge u_sync_clk (
        .i_clk   (i_sys_clk),
        .i_rst   (i_rst),
        .i_async (io_bus.spi_clk),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    spi_slave_sync_edge u_sync_csn (
        .i_clk   (i_sys_clk),
        .i_rst   (i_rst),
        .i_async (io_bus.spi_csn),
        .o_rise  (w_csn_rise),
        .o_fall  (w_csn_fall)
    );

    // MOSI shares the clock's two-flop latency, so it is sampled alongside the detected rise.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= io_bus.spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_cnt_inc = r_bit_cnt + 1'b1;

    always_comb begin
        w_state_next         = r_state;
        w_bit_cnt_next       = r_bit_cnt;
        w_rx_next            = r_rx_shift;
        w_tx_next            = r_tx_shift;
        w_hold_next          = r_hold;
        w_hold_full_next     = r_hold_full;
        w_data_recv_next     = r_data_recv;
        w_data_recv_vld_next = 1'b0;
        w_tx_underrun_next   = 1'b0;
        w_miso_next          = r_miso;
        w_miso_oe_next       = r_miso_oe;
        w_skip_fall_next     = r_skip_fall;
        w_reload             = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_csn_fall) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_state_next     = StShift;
                w_reload         = 1'b1;
                w_miso_oe_next   = 1'b1;
                w_bit_cnt_next   = '0;
                w_skip_fall_next = 1'b0;
            end
            StShift: begin
                // CSN rise wins over a coincident clock edge; partial RX bits are dropped.
                if (w_csn_rise) begin
                    w_state_next     = StIdle;
                    w_bit_cnt_next   = '0;
                    w_rx_next        = '0;
                    w_miso_next      = 1'b0;
                    w_miso_oe_next   = 1'b0;
                    w_skip_fall_next = 1'b0;
                end else if (w_clk_rise) begin
                    w_rx_next = RxMsbFirst ? {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync}
                                           : {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]};
                    if (w_cnt_inc == CntW'(DATA_WIDTH)) begin
                        w_data_recv_next     = w_rx_next;
                        w_data_recv_vld_next = 1'b1;
                        w_bit_cnt_next       = '0;
                        w_reload             = 1'b1;
                        w_skip_fall_next     = 1'b1;
                    end else begin
                        w_bit_cnt_next = w_cnt_inc;
                    end
                end else if (w_clk_fall) begin
                    // The fall right after a reload keeps the new word's first bit on MISO.
                    if (r_skip_fall) begin
                        w_skip_fall_next = 1'b0;
                    end else begin
                        w_tx_next   = tx_advance(r_tx_shift);
                        w_miso_next = first_bit(w_tx_next);
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_reload) begin
            if (r_hold_full) begin
                w_tx_next        = r_hold;
                w_hold_full_next = 1'b0;
            end else if (io_bus.tx_vld) begin
                w_tx_next = io_bus.tx_data;
            end else begin
                w_tx_next          = '0;
                w_tx_underrun_next = 1'b1;
            end
            w_miso_next = first_bit(w_tx_next);
        end else if (io_bus.tx_vld && !r_hold_full) begin
            w_hold_next      = io_bus.tx_data;
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_bit_cnt       <= '0;
            r_rx_shift      <= '0;
            r_tx_shift      <= '0;
            r_hold          <= '0;
            r_hold_full     <= 1'b0;
            r_data_recv     <= '0;
            r_data_recv_vld <= 1'b0;
            r_tx_underrun   <= 1'b0;
            r_miso          <= 1'b0;
            r_miso_oe       <= 1'b0;
            r_skip_fall     <= 1'b0;
        end else begin
            r_bit_cnt       <= w_bit_cnt_next;
            r_rx_shift      <= w_rx_next;
            r_tx_shift      <= w_tx_next;
            r_hold          <= w_hold_next;
            r_hold_full     <= w_hold_full_next;
            r_data_recv     <= w_data_recv_next;
            r_data_recv_vld <= w_data_recv_vld_next;
            r_tx_underrun   <= w_tx_underrun_next;
            r_miso          <= w_miso_next;
            r_miso_oe       <= w_miso_oe_next;
            r_skip_fall     <= w_skip_fall_next;
        end
    end

    assign io_bus.spi_miso      = r_miso;
    assign io_bus.spi_miso_oe   = r_miso_oe;
    assign io_bus.tx_rdy        = ~r_hold_full;
    assign io_bus.data_recv     = r_data_recv;
    assign io_bus.data_recv_vld = r_data_recv_vld;
    assign io_bus.tx_underrun   = r_tx_underrun;
    assign io_bus.spi_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master (10 MHz) against a 100 MHz sys_clk.
module tb_spi_slave;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave #(
        .DATA_WIDTH (DW),
        .TX_ORDER   ("MSB_FIRST"),
        .RX_ORDER   ("MSB_FIRST")
    ) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .io_bus    (bus)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    int        vld_cnt  = 0;
    int        und_cnt  = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (bus.data_recv_vld) begin
            vld_cnt++;
            rx_log.push_back(bus.data_recv);
        end
        if (bus.tx_underrun) und_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled on the rising edge.
    task automatic spi_frame(input logic [31:0] mosi_bits, input int nbits,
                             output logic [31:0] miso_bits);
        miso_bits = '0;
        @(negedge clk);
        bus.spi_csn  = 1'b0;
        bus.spi_mosi = mosi_bits[nbits-1];
        #100;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = mosi_bits[i];
            #50;
            bus.spi_clk  = 1'b1;
            miso_bits[i] = bus.spi_miso;
            #50;
            bus.spi_clk  = 1'b0;
        end
        #50;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        #100;
    endtask

    task automatic push(input string name, input logic [7:0] d);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (bus.tx_rdy) begin
                bus.tx_data = d;
                bus.tx_vld  = 1'b1;
                @(negedge clk);
                bus.tx_vld  = 1'b0;
                done        = 1'b1;
            end
        end
        chk(name, {31'b0, done}, 32'd1);
    endtask

    typedef struct {
        bit         preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] m;
    int          vb, ub, lb;
    bit          seen;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.spi_clk  = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = '0;
        bus.tx_vld   = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        chk("rst_miso",      {31'b0, bus.spi_miso},      32'd0);
        chk("rst_miso_oe",   {31'b0, bus.spi_miso_oe},   32'd0);
        chk("rst_data_recv", {24'b0, bus.data_recv},     32'd0);
        chk("rst_vld",       {31'b0, bus.data_recv_vld}, 32'd0);
        chk("rst_underrun",  {31'b0, bus.tx_underrun},   32'd0);
        chk("rst_busy",      {31'b0, bus.spi_busy},      32'd0);
        chk("rst_tx_rdy",    {31'b0, bus.tx_rdy},        32'd1);
        repeat (5) @(negedge clk);

        // Single 8-bit frames; the final word boundary also reloads from an empty holding
        // register, so every frame sees one boundary underrun plus one more if LOAD was empty.
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 1};
        vecs[1] = '{1'b0, 8'h00, 8'h81, 8'h81, 8'h00, 2};
        vecs[2] = '{1'b1, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 1};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h01, 8'h80, 1};
        for (int v = 0; v < 4; v++) begin
            vb = vld_cnt;
            ub = und_cnt;
            if (vecs[v].preload) push($sformatf("v%0d_push", v), vecs[v].tx);
            spi_frame({24'b0, vecs[v].mosi}, 8, m);
            chk($sformatf("v%0d_rx", v),       {24'b0, bus.data_recv}, {24'b0, vecs[v].exp_rx});
            chk($sformatf("v%0d_vld_cnt", v),  vld_cnt - vb,           32'd1);
            chk($sformatf("v%0d_miso", v),     m,                      {24'b0, vecs[v].exp_miso});
            chk($sformatf("v%0d_underrun", v), und_cnt - ub,           vecs[v].exp_und);
            chk($sformatf("v%0d_tx_rdy", v),   {31'b0, bus.tx_rdy},    32'd1);
        end

        // Three back-to-back words, holding refilled as it drains (fourth word covers the
        // last boundary reload).
        vb = vld_cnt;
        ub = und_cnt;
        lb = rx_log.size();
        push("b2b_push0", 8'hA1);
        fork
            spi_frame({8'h0, 8'h11, 8'h22, 8'h33}, 24, m);
            begin
                push("b2b_push1", 8'hB2);
                push("b2b_push2", 8'hC3);
                push("b2b_push3", 8'hD4);
            end
        join
        chk("b2b_vld_cnt",  vld_cnt - vb, 32'd3);
        chk("b2b_underrun", und_cnt - ub, 32'd0);
        chk("b2b_miso",     m,            32'h00A1B2C3);
        if (rx_log.size() >= lb + 3) begin
            chk("b2b_rx0", {24'b0, rx_log[lb]},     32'h11);
            chk("b2b_rx1", {24'b0, rx_log[lb + 1]}, 32'h22);
            chk("b2b_rx2", {24'b0, rx_log[lb + 2]}, 32'h33);
        end
        chk("b2b_tx_rdy", {31'b0, bus.tx_rdy}, 32'd1);

        // Abort after five bits: nothing delivered, last word held, next frame clean.
        vb = vld_cnt;
        ub = und_cnt;
        push("abort_push", 8'h5C);
        spi_frame({27'b0, 5'b10110}, 5, m);
        chk("abort_vld_cnt",  vld_cnt - vb,             32'd0);
        chk("abort_hold_rx",  {24'b0, bus.data_recv},   32'h33);
        chk("abort_busy",     {31'b0, bus.spi_busy},    32'd0);
        chk("abort_oe",       {31'b0, bus.spi_miso_oe}, 32'd0);
        chk("abort_underrun", und_cnt - ub,             32'd0);
        vb = vld_cnt;
        push("after_abort_push", 8'h69);
        spi_frame({24'b0, 8'h96}, 8, m);
        chk("after_abort_rx",   {24'b0, bus.data_recv}, 32'h96);
        chk("after_abort_miso", m,                      32'h69);
        chk("after_abort_vld",  vld_cnt - vb,           32'd1);

        // tx_vld presented exactly in the LOAD cycle with holding empty: bypass, no LOAD underrun.
        vb   = vld_cnt;
        ub   = und_cnt;
        seen = 1'b0;
        fork
            spi_frame({24'b0, 8'h5E}, 8, m);
            begin
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.spi_busy) begin
                        seen        = 1'b1;
                        bus.tx_data = 8'h6B;
                        bus.tx_vld  = 1'b1;
                        @(negedge clk);
                        bus.tx_vld  = 1'b0;
                    end
                end
            end
        join
        chk("bypass_busy_seen", {31'b0, seen},          32'd1);
        chk("bypass_miso",      m,                      32'h6B);
        chk("bypass_rx",        {24'b0, bus.data_recv}, 32'h5E);
        chk("bypass_underrun",  und_cnt - ub,           32'd1);
        chk("bypass_tx_rdy",    {31'b0, bus.tx_rdy},    32'd1);
        chk("bypass_vld",       vld_cnt - vb,           32'd1);

        // Reset pulsed mid-word.
        push("rstmid_push", 8'h3C);
        fork
            spi_frame({24'b0, 8'hC3}, 8, m);
            begin
                repeat (35) @(negedge clk);
                chk("rstmid_busy_pre", {31'b0, bus.spi_busy},    32'd1);
                chk("rstmid_oe_pre",   {31'b0, bus.spi_miso_oe}, 32'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rstmid_data_recv", {24'b0, bus.data_recv},     32'd0);
                chk("rstmid_vld",       {31'b0, bus.data_recv_vld}, 32'd0);
                chk("rstmid_underrun",  {31'b0, bus.tx_underrun},   32'd0);
                chk("rstmid_busy",      {31'b0, bus.spi_busy},      32'd0);
                chk("rstmid_oe",        {31'b0, bus.spi_miso_oe},   32'd0);
                chk("rstmid_miso",      {31'b0, bus.spi_miso},      32'd0);
                chk("rstmid_tx_rdy",    {31'b0, bus.tx_rdy},        32'd1);
            end
        join
        vb = vld_cnt;
        push("post_rst_push", 8'h5A);
        spi_frame({24'b0, 8'hA5}, 8, m);
        chk("post_rst_rx",   {24'b0, bus.data_recv}, 32'hA5);
        chk("post_rst_miso", m,                      32'h5A);
        chk("post_rst_vld",  vld_cnt - vb,           32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
